// File: rtl/pwm_pulse_monitor.sv
// pwm_pulse_monitor: resynchronizes and deglitches a PWM line, measures each
// pulse's high time and rise-to-rise period in ticks, classifies it as
// short/long, publishes results over valid/ready and flags loss of signal.
module pwm_pulse_monitor #(
    parameter int CLK_DIV = 2400,
    parameter int CNT_W   = 10,
    parameter int FILT    = 3,
    parameter int THRESH  = 10,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] high_ticks,
    output logic [CNT_W-1:0] period_ticks,
    output logic             is_long,
    output logic             timeout,
    output logic             overrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FLT_W = (FILT > 1) ? $clog2(FILT + 1) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILT - 1);
    localparam logic [TO_W-1:0]  TO_LIM   = TO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    // Front end
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [FLT_W-1:0] fcnt_q, fcnt_d;
    logic             f_q, f_d;
    logic             f_dly_q, f_dly_d;
    logic             rise, fall;

    // Tick divider and counters
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    logic [CNT_W-1:0] hcnt_q, hcnt_d, hcnt_inc;
    logic [CNT_W-1:0] pcnt_q, pcnt_d, pcnt_inc;
    logic [TO_W-1:0]  scnt_q, scnt_d, scnt_inc;
    logic             to_hit;

    // Measurement state machine
    state_t           state_q, state_d;
    logic [CNT_W-1:0] h_lat_q, h_lat_d;
    logic             publish;

    // Output holding registers
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             long_q, long_d;
    logic             timeout_q, timeout_d;
    logic             overrun_q, overrun_d;
    logic             accept;

    // Synchronizer, level filter and edge detection of the filtered level
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        sync1_d = pwm_in;
        sync2_d = sync1_q;
        f_d     = f_q;
        fcnt_d  = '0;
        if (sync2_q != f_q) begin
            if (fcnt_q == FLT_LAST) begin
                f_d = sync2_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
        f_dly_d = f_q;
        rise    = f_q & ~f_dly_q;
        fall    = ~f_q & f_dly_q;
    end

    // Tick divider realigned on every rise; saturating tick counters
    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + 1'b1;
        if (rise) begin
            div_d = '0;
        end

        hcnt_inc = (tick && hcnt_q != CNT_MAX) ? hcnt_q + 1'b1 : hcnt_q;
        pcnt_inc = (tick && pcnt_q != CNT_MAX) ? pcnt_q + 1'b1 : pcnt_q;
        scnt_inc = (tick && scnt_q != TO_LIM) ? scnt_q + 1'b1 : scnt_q;

        hcnt_d = rise ? '0 : hcnt_inc;
        pcnt_d = rise ? '0 : pcnt_inc;
        scnt_d = (rise || fall) ? '0 : scnt_inc;

        // An edge in the same cycle beats the timeout.
        to_hit = (scnt_inc == TO_LIM) && !rise && !fall;
    end

    // Next-state logic: IDLE waits for a rise, HIGH latches the high time, LOW publishes
    always_comb begin
        state_d   = state_q;
        h_lat_d   = h_lat_q;
        timeout_d = timeout_q;
        publish   = 1'b0;
        if (rise) begin
            timeout_d = 1'b0;
        end
        unique case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (fall) begin
                    h_lat_d = hcnt_inc;
                    state_d = S_LOW;
                end else if (to_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_LOW: begin
                if (rise) begin
                    publish = 1'b1;
                    state_d = S_HIGH;
                end else if (to_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output handshake: load on publish when free or being drained, otherwise flag overrun
    always_comb begin
        out_valid_d = out_valid_q;
        high_d      = high_q;
        period_d    = period_q;
        long_d      = long_q;
        overrun_d   = overrun_q;
        accept      = out_valid_q & out_ready;
        if (accept) begin
            out_valid_d = 1'b0;
        end
        if (publish) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                high_d      = h_lat_q;
                period_d    = pcnt_inc;
                long_d      = (int'(h_lat_q) >= THRESH);
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            fcnt_q      <= '0;
            f_q         <= 1'b0;
            f_dly_q     <= 1'b0;
            div_q       <= '0;
            hcnt_q      <= '0;
            pcnt_q      <= '0;
            scnt_q      <= '0;
            state_q     <= S_IDLE;
            h_lat_q     <= '0;
            out_valid_q <= 1'b0;
            high_q      <= '0;
            period_q    <= '0;
            long_q      <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            fcnt_q      <= fcnt_d;
            f_q         <= f_d;
            f_dly_q     <= f_dly_d;
            div_q       <= div_d;
            hcnt_q      <= hcnt_d;
            pcnt_q      <= pcnt_d;
            scnt_q      <= scnt_d;
            state_q     <= state_d;
            h_lat_q     <= h_lat_d;
            out_valid_q <= out_valid_d;
            high_q      <= high_d;
            period_q    <= period_d;
            long_q      <= long_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign high_ticks   = high_q;
    assign period_ticks = period_q;
    assign is_long      = long_q;
    assign timeout      = timeout_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_pwm_pulse_monitor.sv
// tb_pwm_pulse_monitor: directed checks of three monitor instances
// (nominal/backpressure/reset, loss of signal, counter saturation).
module tb_pwm_pulse_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: nominal, long, glitch, backpressure, reset mid-high
    logic       rst_a, pwm_a, ready_a, valid_a, long_a, to_a, ovr_a;
    logic [9:0] high_a, period_a;
    // Instance B: loss of signal with TIMEOUT=50
    logic       rst_b, pwm_b, ready_b, valid_b, long_b, to_b, ovr_b;
    logic [9:0] high_b, period_b;
    // Instance C: 4-bit counters, saturation
    logic       rst_c, pwm_c, ready_c, valid_c, long_c, to_c, ovr_c;
    logic [3:0] high_c, period_c;

    pwm_pulse_monitor #(.CLK_DIV(4), .CNT_W(10), .FILT(3), .THRESH(10), .TIMEOUT(1000)) u_dut_a (
        .clk(clk), .rst(rst_a), .pwm_in(pwm_a), .out_valid(valid_a), .out_ready(ready_a),
        .high_ticks(high_a), .period_ticks(period_a), .is_long(long_a), .timeout(to_a), .overrun(ovr_a)
    );

    pwm_pulse_monitor #(.CLK_DIV(4), .CNT_W(10), .FILT(3), .THRESH(10), .TIMEOUT(50)) u_dut_b (
        .clk(clk), .rst(rst_b), .pwm_in(pwm_b), .out_valid(valid_b), .out_ready(ready_b),
        .high_ticks(high_b), .period_ticks(period_b), .is_long(long_b), .timeout(to_b), .overrun(ovr_b)
    );

    pwm_pulse_monitor #(.CLK_DIV(4), .CNT_W(4), .FILT(3), .THRESH(10), .TIMEOUT(100)) u_dut_c (
        .clk(clk), .rst(rst_c), .pwm_in(pwm_c), .out_valid(valid_c), .out_ready(ready_c),
        .high_ticks(high_c), .period_ticks(period_c), .is_long(long_c), .timeout(to_c), .overrun(ovr_c)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance n cycles; inputs change and outputs are sampled on the falling edge.
    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_a = 1'b1; pwm_a = 1'b0; ready_a = 1'b0;
        rst_b = 1'b1; pwm_b = 1'b0; ready_b = 1'b0;
        rst_c = 1'b1; pwm_c = 1'b0; ready_c = 1'b0;
        hold(4);
        check("rst_valid",   valid_a,  0);
        check("rst_high",    high_a,   0);
        check("rst_period",  period_a, 0);
        check("rst_long",    long_a,   0);
        check("rst_timeout", to_a,     0);
        check("rst_overrun", ovr_a,    0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        hold(10);

        // ---- A: short pulse p1 (no result yet), then rise of p2 (long pulse)
        pwm_a = 1'b1; hold(24);
        pwm_a = 1'b0; hold(784);
        check("nom_no_first_result", valid_a, 0);
        pwm_a = 1'b1; hold(5);
        check("nom_valid_at_frise", valid_a, 0);
        hold(1);
        check("nom_valid_frise_p1", valid_a, 1);
        check("nom_high",   high_a,   6);
        check("nom_period", period_a, 202);
        check("nom_long",   long_a,   0);
        ready_a = 1'b1; hold(1); ready_a = 1'b0;
        check("nom_accept_drop", valid_a, 0);
        hold(57);                       // 64 high cycles in total
        pwm_a = 1'b0; hold(744);

        // ---- A: rise of p3 publishes the long pulse; p3 carries a 2-cycle glitch
        pwm_a = 1'b1; hold(6);
        check("long_valid",  valid_a,  1);
        check("long_high",   high_a,   16);
        check("long_period", period_a, 202);
        check("long_long",   long_a,   1);
        ready_a = 1'b1; hold(1); ready_a = 1'b0;
        hold(3);
        pwm_a = 1'b0; hold(2);
        pwm_a = 1'b1; hold(12);         // 24 high cycles in total around the glitch
        pwm_a = 1'b0; hold(784);

        // ---- A: rise of p4 publishes the glitched pulse; keep out_ready low
        pwm_a = 1'b1; hold(6);
        check("glitch_valid",   valid_a,  1);
        check("glitch_high",    high_a,   6);
        check("glitch_period",  period_a, 202);
        check("glitch_overrun", ovr_a,    0);
        hold(58);                       // 64 high cycles
        pwm_a = 1'b0; hold(744);

        // ---- A: rise of p5 -> second result dropped
        pwm_a = 1'b1; hold(6);
        check("bp_valid",   valid_a,  1);
        check("bp_high",    high_a,   6);
        check("bp_period",  period_a, 202);
        check("bp_long",    long_a,   0);
        check("bp_overrun", ovr_a,    1);
        ready_a = 1'b1; hold(1); ready_a = 1'b0;
        check("bp_accept_drop", valid_a, 0);
        check("bp_overrun_sticky", ovr_a, 1);

        // ---- A: reset while in HIGH
        hold(5);
        rst_a = 1'b1; pwm_a = 1'b0; hold(1);
        check("rmid_valid",   valid_a,  0);
        check("rmid_high",    high_a,   0);
        check("rmid_period",  period_a, 0);
        check("rmid_long",    long_a,   0);
        check("rmid_timeout", to_a,     0);
        check("rmid_overrun", ovr_a,    0);
        hold(2);
        rst_a = 1'b0; hold(20);
        pwm_a = 1'b1; hold(24);
        pwm_a = 1'b0; hold(784);
        check("rmid_no_result_first_rise", valid_a, 0);
        pwm_a = 1'b1; hold(6);
        check("rmid_res_valid",  valid_a,  1);
        check("rmid_res_high",   high_a,   6);
        check("rmid_res_period", period_a, 202);
        pwm_a = 1'b0;

        // ---- B: loss of signal
        pwm_b = 1'b1; hold(24);
        pwm_b = 1'b0; hold(150);
        check("los_timeout_early", to_b, 0);
        hold(100);
        check("los_timeout_set", to_b,    1);
        check("los_no_publish",  valid_b, 0);
        pwm_b = 1'b1; hold(10);
        check("los_timeout_clear", to_b,    0);
        check("los_no_result",     valid_b, 0);
        hold(14);
        pwm_b = 1'b0; hold(100);
        check("los_no_result_low", valid_b, 0);
        pwm_b = 1'b1; hold(6);
        check("los_res_valid",   valid_b,  1);
        check("los_res_high",    high_b,   6);
        check("los_res_period",  period_b, 31);
        check("los_res_timeout", to_b,     0);
        pwm_b = 1'b0;

        // ---- C: 80-tick period saturates the 4-bit period counter
        pwm_c = 1'b1; hold(40);
        pwm_c = 1'b0; hold(280);
        pwm_c = 1'b1; hold(6);
        check("sat_valid",  valid_c,  1);
        check("sat_period", period_c, 15);
        check("sat_high",   high_c,   10);
        check("sat_long",   long_c,   1);
        pwm_c = 1'b0;
        hold(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
